reg_dump_uart: RTL

//   Debug register dumper that sits downstream of the CPU debug port and drives reg_sel.
//   On request it walks reg_sel through registers 0..NREG-1 and captures reg_data for each one.
//   It serialises the captured words over a UART 8N1 line (txd) to the host.

---
 rtl/reg_dump_uart_pkg.sv | 24 ++
 rtl/reg_dump_uart_tx.sv | 61 ++++++
 rtl/reg_dump_uart.sv | 106 ++++++++++
 3 files changed

// File: rtl/reg_dump_uart_pkg.sv
// Shared definitions for the register dumper: sequencing states and UART 8N1 framing constants.
package reg_dump_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SEL,
    ST_CAP,
    ST_TXW,
    ST_DONE
  } state_t;

  localparam int   UART_BITS  = 10;
  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP  = 1'b1;

  // Byte n of a word, counted from the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] n);
    int sh;
    sh = 24 - 8 * int'(n);
    return w[sh +: 8];
  endfunction

endpackage

// File: rtl/reg_dump_uart_tx.sv
// UART 8N1 byte transmitter; ready rises during the last stop-bit cycle so a
// byte offered then starts on the very next cycle with no idle gap.
module uart_tx_byte
  import reg_dump_uart_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       valid,
  output logic       ready,
  output logic       txd
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(UART_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_BITS - 1);

  logic                 r_active;
  logic [DIV_W-1:0]     r_div;
  logic [BIT_W-1:0]     r_bit;
  logic [UART_BITS-1:0] r_frame;
  logic                 w_bit_end;
  logic                 w_last;
  logic                 w_accept;

  assign w_bit_end = (r_div == DIV_LAST);
  assign w_last    = r_active && w_bit_end && (r_bit == BIT_LAST);
  assign ready     = !r_active || w_last;
  assign w_accept  = valid && ready;
  assign txd       = r_active ? r_frame[0] : UART_STOP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
    end else if (w_accept) begin
      r_active <= 1'b1;
      r_div    <= '0;
      r_bit    <= '0;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_div <= '0;
        if (r_bit == BIT_LAST) r_active <= 1'b0;
        else                   r_bit    <= r_bit + 1'b1;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  // Shift register holds the whole frame; bit 0 is always the one on the line.
  always_ff @(posedge clk) begin
    if (w_accept)                   r_frame <= {UART_STOP, din, UART_START};
    else if (r_active && w_bit_end) r_frame <= {UART_STOP, r_frame[UART_BITS-1:1]};
  end

endmodule

// File: rtl/reg_dump_uart.sv
// Debug register dumper: walks reg_sel over 0..NREG-1, captures each word and
// streams header + words MSB byte first over a UART 8N1 line.
module reg_dump_uart
  import reg_dump_uart_pkg::*;
#(
  parameter int         CLK_DIV  = 868,
  parameter int         NREG     = 32,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dump_req,
  input  logic [31:0] reg_data,
  output logic [4:0]  reg_sel,
  output logic        txd,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] IDX_LAST = 5'(NREG - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_idx;
  logic [2:0]  r_bcnt;
  logic [31:0] r_word;
  logic        w_tx_valid;
  logic        w_tx_ready;
  logic [7:0]  w_tx_din;
  logic        w_tx_accept;

  uart_tx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .din  (w_tx_din),
    .valid(w_tx_valid),
    .ready(w_tx_ready),
    .txd  (txd)
  );

  assign w_tx_accept = w_tx_valid && w_tx_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_tx_valid  = 1'b0;
    w_tx_din    = HDR_BYTE;
    case (r_state)
      ST_IDLE: begin
        // Header is handed over on the accepting edge so its start bit coincides with busy.
        if (dump_req) begin
          w_tx_valid  = 1'b1;
          w_state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        if (w_tx_ready) w_state_nxt = ST_SEL;
      end
      ST_SEL: w_state_nxt = ST_CAP;
      ST_CAP: begin
        // First byte comes straight from reg_data to keep the inter-register gap at two cycles.
        w_tx_valid  = 1'b1;
        w_tx_din    = reg_data[31:24];
        w_state_nxt = ST_TXW;
      end
      ST_TXW: begin
        if (r_bcnt != 3'd4) begin
          w_tx_valid = 1'b1;
          w_tx_din   = word_byte(r_word, r_bcnt[1:0]);
        end else if (w_tx_ready) begin
          w_state_nxt = (r_idx == IDX_LAST) ? ST_DONE : ST_SEL;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE)
        r_idx <= '0;
      else if (r_state == ST_TXW && w_state_nxt == ST_SEL)
        r_idx <= r_idx + 5'd1;
      if (r_state == ST_CAP)
        r_bcnt <= 3'd1;
      else if (r_state == ST_TXW && w_tx_accept)
        r_bcnt <= r_bcnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_CAP) r_word <= reg_data;
  end

  assign busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done    = (r_state == ST_DONE);
  assign reg_sel = (r_state == ST_SEL || r_state == ST_CAP || r_state == ST_TXW) ? r_idx : 5'd0;

endmodule
